// File: rtl/prod_arbiter_fsm.sv
// prod_arbiter_fsm: arbitrates N_CH producers into one buffer write port.
// Each channel has a start button. A common stop button and buffer full/empty
// back-pressure control the flow. A channel can be switched while running.
// The led output shows the state one-hot.
// Optional macro DRAIN_TIMEOUT_EN adds a drain watchdog that forces IDLE
// after TIMEOUT_CYC cycles in DRAIN. Without the macro, drain_timeout is tied to 0.
module prod_arbiter_fsm #(
  parameter int N_CH        = 2,
  parameter int W           = 16,
  parameter int CHW         = 3,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH-1:0]     start_req,
  input  logic                stop_req,
  input  logic                buffer_full,
  input  logic                buffer_empty,
  input  logic                data_valid_2,
  input  logic [N_CH*W-1:0]   prod_data,
  output logic [N_CH-1:0]     prod_en,
  output logic [W-1:0]        data_1,
  output logic                data_1_en,
  output logic [CHW-1:0]      active_ch,
  output logic [3:0]          led,
  output logic                drain_timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COMM  = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CHW-1:0]  ch_sel_q, ch_sel_d;

  // Button history plus the registered rising edges. The registered edges
  // drive the FSM, so a button acts one cycle after its level is sampled.
  logic [N_CH-1:0] start_prev_q, start_edge_q;
  logic            stop_prev_q, stop_edge_q;

  logic            any_start;
  logic            other_start;
  logic [CHW-1:0]  winner;
  logic [N_CH-1:0] sel_onehot;
  logic            drain_exit;
  logic            in_comm;
  logic [W-1:0]    data_mux;

  // An impossible parameter set leaves a visible marker in the hierarchy.
  // Elaboration stays quiet because the counter below may not be built.
  if (N_CH < 2 || N_CH > 8 || (1 << CHW) < N_CH || TIMEOUT_CYC < 1) begin : g_cfg_invalid
  end

  // Edge detectors: prev resets low, so a button held through reset gives one edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_prev_q <= '0;
      start_edge_q <= '0;
      stop_prev_q  <= 1'b0;
      stop_edge_q  <= 1'b0;
    end else begin
      start_prev_q <= start_req;
      start_edge_q <= start_req & ~start_prev_q;
      stop_prev_q  <= stop_req;
      stop_edge_q  <= stop_req & ~stop_prev_q;
    end
  end

  // One-hot decode of the selected channel. This drives both the enables and the data mux.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_sel
    assign sel_onehot[gi] = (ch_sel_q == CHW'(gi));
  end

  // Highest-index start edge wins when several arrive together
  always_comb begin
    winner = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (start_edge_q[i]) begin
        winner = CHW'(i);
      end
    end
  end

  assign any_start   = |start_edge_q;
  // A start edge on any channel other than the current one requests a switch
  assign other_start = |(start_edge_q & ~sel_onehot);
  assign drain_exit  = buffer_empty & ~data_valid_2;

`ifdef DRAIN_TIMEOUT_EN
  // The watchdog limit is held in the narrowest counter that can reach TIMEOUT_CYC-1
  localparam int CNTW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNTW-1:0] WD_LIMIT = CNTW'(TIMEOUT_CYC - 1);

  logic [CNTW-1:0] wd_cnt_q, wd_cnt_d;
  logic            wd_fire;
  logic            drain_timeout_q;
`endif

  // Next-state and channel-select logic
  always_comb begin
    state_d  = state_q;
    ch_sel_d = ch_sel_q;
`ifdef DRAIN_TIMEOUT_EN
    wd_fire  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_start) begin
          state_d  = S_COMM;
          ch_sel_d = winner;
        end
      end
      S_COMM: begin
        if (stop_edge_q) begin
          state_d = S_DRAIN;
        end else if (other_start) begin
          ch_sel_d = winner;
        end else if (buffer_full) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (stop_edge_q) begin
          state_d = S_DRAIN;
        end else if (other_start) begin
          ch_sel_d = winner;
        end else if (!buffer_full) begin
          state_d = S_COMM;
        end
      end
      S_DRAIN: begin
        if (drain_exit) begin
          state_d = S_IDLE;
`ifdef DRAIN_TIMEOUT_EN
        end else if (wd_cnt_q == WD_LIMIT) begin
          state_d = S_IDLE;
          wd_fire = 1'b1;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef DRAIN_TIMEOUT_EN
  // The counter advances only while the FSM stays in DRAIN.
  // Every fresh entry starts it again from zero.
  always_comb begin
    wd_cnt_d = '0;
    if (state_q == S_DRAIN && state_d == S_DRAIN) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  // Watchdog counter and its one-cycle timeout pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q        <= '0;
      drain_timeout_q <= 1'b0;
    end else begin
      wd_cnt_q        <= wd_cnt_d;
      drain_timeout_q <= wd_fire;
    end
  end

  assign drain_timeout = drain_timeout_q;
`else
  assign drain_timeout = 1'b0;
`endif

  // State and channel-select registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ch_sel_q <= '0;
    end else begin
      state_q  <= state_d;
      ch_sel_q <= ch_sel_d;
    end
  end

  assign in_comm = (state_q == S_COMM);

  // Enables come only from the registered one-hot select.
  // Because of this, two enables can never be high together.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_en
    assign prod_en[gi] = in_comm & sel_onehot[gi] & ~buffer_full;
  end

  // AND-OR data mux: only the selected slice passes, and only while in COMM
  always_comb begin
    data_mux = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (in_comm && sel_onehot[i]) begin
        data_mux = data_mux | prod_data[i*W +: W];
      end
    end
  end

  assign data_1    = data_mux;
  assign data_1_en = |prod_en;
  assign active_ch = ch_sel_q;
  assign led       = {state_q == S_DRAIN, state_q == S_WAIT,
                      state_q == S_COMM,  state_q == S_IDLE};

endmodule

// File: tb/tb_prod_arbiter_fsm.sv
// tb_prod_arbiter_fsm: directed and random stimulus for prod_arbiter_fsm.
// Every cycle is compared against a mode/channel reference model of the arbiter rules.
module tb_prod_arbiter_fsm;

  localparam int N_CH = 4;
  localparam int W    = 16;
  localparam int CHW  = 3;
  localparam int TOC  = 8;

  localparam int M_IDLE  = 0;
  localparam int M_COMM  = 1;
  localparam int M_WAIT  = 2;
  localparam int M_DRAIN = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_CH-1:0]   start_req;
  logic              stop_req;
  logic              buffer_full;
  logic              buffer_empty;
  logic              data_valid_2;
  logic [N_CH*W-1:0] prod_data;
  logic [N_CH-1:0]   prod_en;
  logic [W-1:0]      data_1;
  logic              data_1_en;
  logic [CHW-1:0]    active_ch;
  logic [3:0]        led;
  logic              drain_timeout;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int              m_mode;
  int              m_ch;
  bit [N_CH-1:0]   m_prev_s, m_edge_s;
  bit              m_prev_p, m_edge_p;
  int              m_wd;
  bit              m_dt;

  prod_arbiter_fsm #(.N_CH(N_CH), .W(W), .CHW(CHW), .TIMEOUT_CYC(TOC)) dut (
    .clk(clk), .rst(rst), .start_req(start_req), .stop_req(stop_req),
    .buffer_full(buffer_full), .buffer_empty(buffer_empty),
    .data_valid_2(data_valid_2), .prod_data(prod_data), .prod_en(prod_en),
    .data_1(data_1), .data_1_en(data_1_en), .active_ch(active_ch),
    .led(led), .drain_timeout(drain_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_ch = 0;
    m_prev_s = '0; m_edge_s = '0; m_prev_p = 0; m_edge_p = 0;
    m_wd = 0; m_dt = 0;
  endtask

  // One rising clock edge of the arbiter rules, using the current inputs
  task automatic model_clock();
    int win; bit any, other, exit_ok, fire; int nmode;
    win = 0; any = 0; other = 0; fire = 0;
    for (int i = 0; i < N_CH; i++) if (m_edge_s[i]) begin
      win = i; any = 1;
      if (i != m_ch) other = 1;
    end
    exit_ok = buffer_empty && !data_valid_2;
    nmode = m_mode;
    if (m_mode == M_IDLE) begin
      if (any) begin nmode = M_COMM; m_ch = win; end
    end else if (m_mode == M_COMM || m_mode == M_WAIT) begin
      if (m_edge_p) nmode = M_DRAIN;
      else if (other) m_ch = win;
      else if (m_mode == M_COMM && buffer_full) nmode = M_WAIT;
      else if (m_mode == M_WAIT && !buffer_full) nmode = M_COMM;
    end else begin
      if (exit_ok) nmode = M_IDLE;
`ifdef DRAIN_TIMEOUT_EN
      else if (m_wd == TOC - 1) begin nmode = M_IDLE; fire = 1; end
`endif
    end
    m_wd = (m_mode == M_DRAIN && nmode == M_DRAIN) ? m_wd + 1 : 0;
    m_dt = fire;
    m_mode = nmode;
    m_edge_s = start_req & ~m_prev_s; m_prev_s = start_req;
    m_edge_p = stop_req & ~m_prev_p;  m_prev_p = stop_req;
  endtask

  task automatic check_outputs(input string ctx);
    logic [N_CH-1:0] e_en;
    logic [W-1:0]    e_data;
    e_en   = (m_mode == M_COMM && !buffer_full) ? N_CH'(1 << m_ch) : '0;
    e_data = (m_mode == M_COMM) ? prod_data[m_ch*W +: W] : '0;
    check({ctx, ".led"}, 64'(led), 64'(1 << m_mode));
    check({ctx, ".prod_en"}, 64'(prod_en), 64'(e_en));
    check({ctx, ".data_1"}, 64'(data_1), 64'(e_data));
    check({ctx, ".data_1_en"}, 64'(data_1_en), 64'(e_en != 0));
    check({ctx, ".active_ch"}, 64'(active_ch), 64'(m_ch));
    check({ctx, ".drain_timeout"}, 64'(drain_timeout), 64'(m_dt));
    check({ctx, ".en_onehot0"}, 64'($countones(prod_en) <= 1), 64'(1));
  endtask

  // Drive inputs at the falling edge, advance one clock, then compare at the next falling edge
  task automatic step(input string ctx, input logic [N_CH-1:0] s, input logic p,
                      input logic f, input logic e, input logic v);
    start_req = s; stop_req = p; buffer_full = f; buffer_empty = e; data_valid_2 = v;
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check_outputs(ctx);
    $display("step %-10s start=%b stop=%b full=%b empty=%b dv2=%b led=%b en=%b ch=%0d data=%h",
             ctx, s, p, f, e, v, led, prod_en, active_ch, data_1);
  endtask

  initial begin
    rst = 1'b1; start_req = '0; stop_req = 0; buffer_full = 0;
    buffer_empty = 1; data_valid_2 = 0;
    prod_data = {16'h4444, 16'h3333, 16'h2222, 16'h0005};
    model_reset();
    repeat (2) @(negedge clk);
    check("reset.led", 64'(led), 64'h1);
    check("reset.prod_en", 64'(prod_en), 64'h0);
    check("reset.data_1", 64'(data_1), 64'h0);
    check("reset.data_1_en", 64'(data_1_en), 64'h0);
    check("reset.active_ch", 64'(active_ch), 64'h0);
    check("reset.drain_timeout", 64'(drain_timeout), 64'h0);
    rst = 1'b0;

    // start channel 0: COMM two clocks after the rise
    step("start0", 4'b0001, 0, 0, 1, 0);
    check("start0.still_idle", 64'(led), 64'h1);
    step("start0b", 4'b0000, 0, 0, 1, 0);
    check("start0.led", 64'(led), 64'h2);
    check("start0.en", 64'(prod_en), 64'h1);
    check("start0.data", 64'(data_1), 64'h0005);
    check("start0.den", 64'(data_1_en), 64'h1);

    // back-pressure
    buffer_full = 1'b1;
    #1 check("full.en_immediate", 64'(prod_en), 64'h0);
    step("full", 4'b0000, 0, 1, 1, 0);
    check("full.led", 64'(led), 64'h4);
    step("unfull", 4'b0000, 0, 0, 1, 0);
    check("unfull.led", 64'(led), 64'h2);
    check("unfull.en", 64'(prod_en), 64'h1);

    // switch from ch0 to ch1
    step("sw1", 4'b0010, 0, 0, 1, 0);
    step("sw1b", 4'b0000, 0, 0, 1, 0);
    check("sw1.ch", 64'(active_ch), 64'h1);
    check("sw1.en", 64'(prod_en), 64'h2);

    // stop together with start0: stop wins, and ch1 is held
    step("stopsw", 4'b0001, 1, 0, 0, 0);
    step("stopswb", 4'b0000, 0, 0, 0, 0);
    check("drain.led", 64'(led), 64'h8);
    check("drain.ch", 64'(active_ch), 64'h1);
    step("drainhold", 4'b0100, 0, 0, 0, 0);
    step("drainhold", 4'b0000, 0, 0, 0, 0);
    step("drainhold", 4'b0000, 0, 0, 1, 1);
    check("drain.dv2_hold", 64'(led), 64'h8);
    step("drainexit", 4'b0000, 0, 0, 1, 0);
    check("drain.exit", 64'(led), 64'h1);

    // simultaneous starts from IDLE: the highest index wins
    step("dual", 4'b0011, 0, 0, 1, 0);
    step("dualb", 4'b0000, 0, 0, 1, 0);
    check("dual.ch", 64'(active_ch), 64'h1);
    check("dual.en", 64'(prod_en), 64'h2);

    // asynchronous reset while in COMM
    rst = 1'b1;
    #1;
    check("arst.led", 64'(led), 64'h1);
    check("arst.en", 64'(prod_en), 64'h0);
    check("arst.den", 64'(data_1_en), 64'h0);
    check("arst.data", 64'(data_1), 64'h0);
    check("arst.ch", 64'(active_ch), 64'h0);
    model_reset();

    // button held through reset release gives exactly one edge
    start_req = 4'b0100;
    @(negedge clk);
    rst = 1'b0;
    step("held", 4'b0100, 0, 0, 1, 0);
    step("heldb", 4'b0100, 0, 0, 1, 0);
    check("held.ch", 64'(active_ch), 64'h2);
    step("heldc", 4'b0100, 0, 0, 1, 0);
    check("held.led", 64'(led), 64'h2);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      logic [N_CH-1:0] s;
      for (int i = 0; i < N_CH; i++) s[i] = ($urandom_range(0, 7) == 0);
      prod_data = {$urandom, $urandom};
      step("rand", s, $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prod_arbiter_fsm.md
Name: prod_arbiter_fsm

Overview:
Parametrised successor to the fixed two-producer control FSM. It arbitrates N_CH data producers into a single buffer write port. It provides per-channel start buttons, a common stop, full/empty back-pressure, an on-the-fly channel switch and a one-hot state LED output. It sits between the raw board buttons, the producer modules (fibonacci, timer, future sources) and the clock-domain wrapper buffer.

Parameters:
N_CH, 2, number of producer channels (2..8)
W, 16, producer data width in bits
CHW, 3, width of the channel index; must satisfy 2**CHW >= N_CH
TIMEOUT_CYC, 1000000, drain watchdog limit in clk cycles; used only with DRAIN_TIMEOUT_EN

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start_req  in  N_CH  raw start button levels, one per channel
stop_req  in  1  raw stop button level
buffer_full  in  1  buffer full flag from the wrapper
buffer_empty  in  1  buffer empty flag from the wrapper
data_valid_2  in  1  consumer side still holds valid data
prod_data  in  N_CH*W  producer outputs, flattened; channel i occupies bits [i*W +: W]
prod_en  out  N_CH  per-channel producer enable
data_1  out  W  selected data toward the buffer
data_1_en  out  1  buffer write enable
active_ch  out  CHW  currently selected channel index
led  out  4  one-hot state indicator: [0] IDLE, [1] COMM, [2] WAIT, [3] DRAIN
drain_timeout  out  1  one-cycle pulse when the drain watchdog fires

Behaviour:
- Edge detection is internal, with one register stage per raw input.
  - rise = in & ~prev.
  - prev resets to 0, so a button held through reset release yields exactly one edge on the first clock.
  - Edges act on the FSM one cycle after the raw level is sampled.
- The state register and ch_sel are registered on the posedge of clk.
- Reset values:
  - state = IDLE, ch_sel = 0, all edge registers = 0, watchdog counter = 0.
  - Outputs: led = 4'b0001, prod_en = 0, data_1 = 0, data_1_en = 0, active_ch = 0, drain_timeout = 0.
- Priority for multiple simultaneous start edges: the highest channel index wins.
- IDLE:
  - Any start edge -> COMM, with ch_sel = winning channel.
  - A stop edge is ignored.
- COMM:
  - Stop edge -> DRAIN. Stop has the highest priority.
  - Else a start edge on a channel != ch_sel -> stay in COMM; ch_sel = winner. This is the switch.
  - Else buffer_full = 1 -> WAIT.
  - A start edge on the same channel is a no-op.
- WAIT:
  - Stop edge -> DRAIN.
  - Else a start edge on another channel updates ch_sel and the FSM stays in WAIT.
  - Else buffer_full = 0 -> COMM.
- DRAIN:
  - buffer_empty = 1 and data_valid_2 = 0 -> IDLE.
  - All start and stop edges are ignored; ch_sel is held.
- Combinational outputs:
  - prod_en[i] = (state == COMM) & (ch_sel == i) & ~buffer_full.
  - data_1_en = |prod_en.
  - data_1 = prod_data slice of ch_sel when state == COMM, else 0.
  - active_ch = ch_sel.
- A channel switch takes effect on prod_en and data_1 in the cycle after the edge is registered. No word from the old channel is written after the switch cycle.
- The switch is glitch-free: at most one prod_en bit is high in any cycle.
- Reset mid-operation returns to IDLE immediately, asynchronously. All outputs take their reset values; no partial write enable survives.

Optional Feature:
DRAIN_TIMEOUT_EN
- Defined:
  - A counter runs only in DRAIN and clears on every DRAIN entry.
  - When it reaches TIMEOUT_CYC-1 with the drain exit condition still false, the FSM forces IDLE and drain_timeout pulses high for exactly one cycle.
  - A normal exit on the same cycle takes precedence, and drain_timeout stays 0.
- Not defined:
  - No counter logic is present.
  - drain_timeout is tied to 0.
  - DRAIN waits indefinitely.

Test Plan:
- Reset with start_req = 0 -> led = 0001, prod_en = 0, data_1 = 0. Pulse start_req[0] -> led = 0010 and prod_en = 01 two cycles after the rise. prod_data ch0 = 16'h0005 -> data_1 = 16'h0005, data_1_en = 1.
- In COMM ch0, raise buffer_full -> led = 0100 next cycle and prod_en = 00 immediately. Drop buffer_full -> led = 0010 and prod_en = 01.
- Pulse start_req[0] and start_req[1] in the same cycle from IDLE -> active_ch = 1, prod_en = 10.
- In COMM ch0, pulse start_req[1] -> active_ch = 1, prod_en = 10 with no cycle where both bits are high. Pulse stop_req and start_req[0] together -> DRAIN, active_ch stays 1.
- In DRAIN with buffer_empty = 0 -> stays DRAIN, and a start pulse is ignored. Set buffer_empty = 1 and data_valid_2 = 1 -> stays DRAIN. Set data_valid_2 = 0 -> led = 0001.
- With DRAIN_TIMEOUT_EN and TIMEOUT_CYC = 8, enter DRAIN with buffer_empty held at 0 -> IDLE after 8 DRAIN cycles, with a single-cycle drain_timeout pulse. Assert rst in COMM -> all outputs reset in the same cycle.
